age_select_logic: RTL and testbench

//  Downstream select stage of the RS wakeup logic: consumes the per-entry request vector and picks the

---
 rtl/age_select_logic_pkg.sv | 6 +
 rtl/age_select_logic_age_matrix.sv | 65 ++++++
 rtl/age_select_logic.sv | 66 ++++++
 tb/tb_age_select_logic.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/age_select_logic_pkg.sv
// Shared sizing for the RS select stage: entry count and entry index type.
package age_select_logic_pkg;
  localparam int RS_ENTRIES = 16;
  localparam int RS_IDX_W   = $clog2(RS_ENTRIES);
  typedef logic [RS_IDX_W-1:0] rs_idx_t;
endpackage

// File: rtl/age_select_logic_age_matrix.sv
// Age matrix: per-entry valid bits plus pairwise "i older than j" bits; picks the
// oldest eligible entry as a one-hot and its encoded index.
module age_select_logic_age_matrix
  import age_select_logic_pkg::*;
#(
  parameter int NUM_ENTRIES = RS_ENTRIES,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_en,
  input  logic [IDX_W-1:0]       alloc_index,
  input  logic                   free_en,
  input  logic [IDX_W-1:0]       free_index,
  input  logic                   flush,
  input  logic [NUM_ENTRIES-1:0] elig,
  output logic [NUM_ENTRIES-1:0] valid,
  output logic [NUM_ENTRIES-1:0] pick_oh,
  output logic [IDX_W-1:0]       pick_index,
  output logic                   pick_any
);
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older;    // older[i][j]: i older than j
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older_t;  // older_t[w][j]: j older than w
  logic [NUM_ENTRIES-1:0] valid_freed, valid_nxt;

  always_comb begin
    valid_freed = valid;
    if (free_en) valid_freed[free_index] = 1'b0;
    valid_nxt = valid_freed;
    if (alloc_en) valid_nxt[alloc_index] = 1'b1;
  end

  // Age bits of freed entries go stale; valid masks them until re-alloc rewrites the row/column.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      older <= '0;
    end else if (flush) begin
      valid <= '0;
    end else begin
      valid <= valid_nxt;
      if (alloc_en) begin
        for (int j = 0; j < NUM_ENTRIES; j++) begin
          if (IDX_W'(j) == alloc_index) older[j] <= '0;
          else                          older[j][alloc_index] <= valid_freed[j];
        end
      end
    end
  end

  for (genvar gw = 0; gw < NUM_ENTRIES; gw++) begin : g_pick
    for (genvar gj = 0; gj < NUM_ENTRIES; gj++) begin : g_col
      assign older_t[gw][gj] = (gw != gj) && older[gj][gw];
    end
    assign pick_oh[gw] = elig[gw] & ~|(elig & older_t[gw]);
  end

  always_comb begin
    pick_index = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      if (pick_oh[i]) pick_index = pick_index | IDX_W'(i);
  end

  assign pick_any = |pick_oh;
endmodule

// File: rtl/age_select_logic.sv
// RS select stage: masks the held entry out of the request vector, registers the
// oldest eligible entry on a valid/ready issue port and returns the grant to wakeup.
module age_select_logic
  import age_select_logic_pkg::*;
#(
  parameter int NUM_ENTRIES = RS_ENTRIES,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_en,
  input  logic [IDX_W-1:0]       alloc_index,
  input  logic                   free_en,
  input  logic [IDX_W-1:0]       free_index,
  input  logic                   flush,
  input  logic [NUM_ENTRIES-1:0] request_vector,
  output logic                   issue_valid,
  output logic [IDX_W-1:0]       issue_index,
  input  logic                   issue_ready,
  output logic                   grant_en,
  output logic [IDX_W-1:0]       grant_index
);
  logic [NUM_ENTRIES-1:0] valid, elig, held_oh, pick_oh;
  logic [IDX_W-1:0]       pick_index;
  logic                   pick_any, fire;

  // The held entry stays masked until wakeup clears its request after the grant.
  assign held_oh = issue_valid ? (NUM_ENTRIES'(1) << issue_index) : '0;
  assign elig    = request_vector & valid & ~held_oh;
  assign fire    = issue_valid & issue_ready;

  age_select_logic_age_matrix #(
    .NUM_ENTRIES(NUM_ENTRIES),
    .IDX_W      (IDX_W)
  ) u_age (
    .clk        (clk),
    .rst        (rst),
    .alloc_en   (alloc_en),
    .alloc_index(alloc_index),
    .free_en    (free_en),
    .free_index (free_index),
    .flush      (flush),
    .elig       (elig),
    .valid      (valid),
    .pick_oh    (pick_oh),
    .pick_index (pick_index),
    .pick_any   (pick_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid <= 1'b0;
      issue_index <= '0;
    end else if (flush) begin
      issue_valid <= 1'b0;
    end else if (issue_valid && free_en && free_index == issue_index) begin
      issue_valid <= 1'b0;
    end else if (!issue_valid || fire) begin
      issue_valid <= pick_any;
      if (pick_any) issue_index <= pick_index;
    end
  end

  assign grant_en    = fire;
  assign grant_index = issue_index;
endmodule

// File: tb/tb_age_select_logic.sv
// Bench for age_select_logic: directed scenarios plus random traffic checked against
// an allocation-order queue model of the RS entries.
module tb_age_select_logic;
  localparam int N = 16;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         alloc_en = 0, free_en = 0, flush = 0, issue_ready = 0;
  logic [W-1:0] alloc_index = '0, free_index = '0;
  logic [N-1:0] request_vector = '0;
  logic         issue_valid, grant_en;
  logic [W-1:0] issue_index, grant_index;

  int checks = 0, passes = 0;
  int age_q[$];      // valid entries, oldest first
  int dut_grants[$];
  bit m_iv;
  int m_idx;

  age_select_logic #(.NUM_ENTRIES(N), .IDX_W(W)) dut (
    .clk(clk), .rst(rst), .alloc_en(alloc_en), .alloc_index(alloc_index),
    .free_en(free_en), .free_index(free_index), .flush(flush),
    .request_vector(request_vector), .issue_valid(issue_valid), .issue_index(issue_index),
    .issue_ready(issue_ready), .grant_en(grant_en), .grant_index(grant_index)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic q_remove(int e);
    for (int k = 0; k < age_q.size(); k++)
      if (age_q[k] == e) begin age_q.delete(k); break; end
  endtask

  task automatic model_reset();
    age_q.delete();
    m_iv = 0;
    m_idx = 0;
  endtask

  // One clock: check outputs mid-cycle, advance the model, then act as wakeup
  // by dropping the request of a granted entry.
  task automatic tick();
    bit fire;
    int w, granted;
    @(negedge clk);
    chk("issue_valid", issue_valid, m_iv);
    if (m_iv) chk("issue_index", issue_index, m_idx);
    chk("grant_en", grant_en, m_iv && issue_ready);
    if (grant_en) begin
      chk("grant_index", grant_index, m_idx);
      dut_grants.push_back(int'(grant_index));
    end
    fire = m_iv && issue_ready;
    granted = m_idx;
    w = -1;
    foreach (age_q[k])
      if (w < 0 && request_vector[age_q[k]] && !(m_iv && m_idx == age_q[k])) w = age_q[k];
    if (flush) m_iv = 0;
    else if (m_iv && free_en && int'(free_index) == m_idx) m_iv = 0;
    else if (!m_iv || fire) begin
      m_iv = (w >= 0);
      if (w >= 0) m_idx = w;
    end
    if (flush) age_q.delete();
    else begin
      if (free_en) q_remove(int'(free_index));
      if (alloc_en) begin q_remove(int'(alloc_index)); age_q.push_back(int'(alloc_index)); end
    end
    @(posedge clk);
    #1;
    if (fire) request_vector[granted] = 1'b0;
  endtask

  task automatic op(bit a, int ai, bit f, int fi, bit fl);
    alloc_en = a; alloc_index = W'(ai);
    free_en = f; free_index = W'(fi);
    flush = fl;
    tick();
    alloc_en = 0; free_en = 0; flush = 0;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_grants(string tag, int exp[$]);
    chk({tag, "_count"}, dut_grants.size(), exp.size());
    for (int i = 0; i < exp.size() && i < dut_grants.size(); i++)
      chk(tag, dut_grants[i], exp[i]);
    dut_grants.delete();
  endtask

  task automatic clean();
    request_vector = '0;
    issue_ready = 1;
    op(0, 0, 0, 0, 1);
    ticks(2);
    dut_grants.delete();
  endtask

  initial begin
    // reset held with all requests set
    rst = 0;
    request_vector = '1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_grant_en", grant_en, 0);
    chk("rst_issue_index", issue_index, 0);
    @(posedge clk); #1;
    rst = 1;
    issue_ready = 1;
    ticks(2);
    chk_grants("rst_grants", '{});
    request_vector = '0;

    // age order
    op(1, 3, 0, 0, 0); op(1, 7, 0, 0, 0); op(1, 1, 0, 0, 0);
    request_vector = N'((1 << 1) | (1 << 3) | (1 << 7));
    ticks(5);
    chk_grants("age_order", '{3, 7, 1});
    clean();

    // stall
    op(1, 5, 0, 0, 0);
    issue_ready = 0;
    request_vector = N'(1 << 5);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", issue_valid, 1);
      chk("stall_index", issue_index, 5);
      chk("stall_grant", grant_en, 0);
      tick();
    end
    issue_ready = 1;
    ticks(3);
    chk_grants("stall", '{5});
    clean();

    // re-age via free and realloc
    op(1, 3, 0, 0, 0); op(1, 9, 0, 0, 0); op(0, 0, 1, 3, 0); op(1, 3, 0, 0, 0);
    request_vector = N'((1 << 3) | (1 << 9));
    ticks(4);
    chk_grants("reage", '{9, 3});
    clean();

    // same-cycle free and alloc of 2 while 6 valid
    op(1, 2, 0, 0, 0); op(1, 6, 0, 0, 0); op(1, 2, 1, 2, 0);
    request_vector = N'((1 << 2) | (1 << 6));
    ticks(4);
    chk_grants("free_alloc", '{6, 2});
    clean();

    // flush while 4 held stalled, then request 4 without alloc
    op(1, 4, 0, 0, 0);
    issue_ready = 0;
    request_vector = N'(1 << 4);
    ticks(2);
    op(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("flush_valid", issue_valid, 0);
    issue_ready = 1;
    request_vector = N'(1 << 4);
    ticks(3);
    chk_grants("flush", '{});
    clean();

    // async reset during a stall
    op(1, 5, 0, 0, 0);
    issue_ready = 0;
    request_vector = N'(1 << 5);
    ticks(2);
    @(negedge clk); #2;
    rst = 0;
    #1;
    chk("arst_valid", issue_valid, 0);
    chk("arst_grant", grant_en, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1;
    issue_ready = 1;
    ticks(3);
    chk_grants("arst", '{});

    // random traffic
    for (int c = 0; c < 600; c++) begin
      alloc_en = ($urandom_range(0, 1) == 1);
      alloc_index = W'($urandom_range(0, N - 1));
      free_en = ($urandom_range(0, 9) < 3);
      free_index = W'($urandom_range(0, N - 1));
      flush = ($urandom_range(0, 49) == 0);
      issue_ready = ($urandom_range(0, 3) != 0);
      request_vector = request_vector | N'($urandom_range(0, 65535) & $urandom_range(0, 65535));
      tick();
    end
    alloc_en = 0; free_en = 0; flush = 0;
    dut_grants.delete();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
